mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port system memory between the CPU and a second bus master (DMA/bootloader). It grants at most one access per cycle with round-robin fairness, and supports bounded locked bursts so a master can stream consecutive words. It returns registered read-valid strobes to the granted requester. It sits between the masters and the memory, in place of the direct CPU-to-memory connection.

## Interface
- ADDR_W, 16, address width (word addressed)
- DATA_W, 32, data width
- MAX_BURST, 8, maximum consecutive locked grants to one owner (≥1)
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request from requester 0 (CPU) / 1 (DMA)
- we0 / we1  in  1  write (1) or read (0), valid with req
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- lock0 / lock1  in  1  request to keep the grant next cycle (burst)
- gnt0 / gnt1  out  1  combinational grant; access performed this cycle
- rvalid0 / rvalid1  out  1  registered; read data for last cycle's granted read
- rdata  out  DATA_W  read data, shared; qualified by rvalid0/rvalid1
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr (synchronous read)

## Operation
- FSM states: OPEN (no owner), LOCKED (owner held, burst_cnt active).
- OPEN arbitration: only one req → grant it. Both req → grant the requester not granted most recently (last_gnt). last_gnt updates on every grant.
- Granted with lock=1 → next state LOCKED. owner is set to the granted requester. burst_cnt is set to 1.
- LOCKED arbitration, evaluated in order:
  - Owner req=1 and burst_cnt<MAX_BURST → grant owner. burst_cnt++. Stay LOCKED if lock=1, else go to OPEN.
  - burst_cnt==MAX_BURST and other req=1 → grant the other requester (forced yield). Its own lock may start a new LOCKED burst.
  - burst_cnt==MAX_BURST and other idle → grant owner. burst_cnt restarts at 1.
  - Owner req=0 → go to OPEN and arbitrate as in OPEN in the same cycle.
- Mux: mem_addr, mem_we, mem_wdata come from the granted requester. With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we = granted we. Never asserted without a grant.
- Read return: on a granted read, rvalidN is asserted the next cycle and rdata=mem_rdata. Writes never produce rvalid.
- A requester must hold req/we/addr/wdata stable until it sees gnt. Requests without grant are not queued internally.

## Timing
- Grant latency: 0 cycles (gnt combinational from req and state). Read data latency: 1 cycle.
- Throughput: one access per cycle, back-to-back, with no bubbles between requesters.
- Reset values: state=OPEN, last_gnt=1 (requester 0 wins the first tie), burst_cnt=0, rvalid0=rvalid1=0.
- While reset=1: gnt0=gnt1=0 and mem_we=0, regardless of req.
- Reset mid-burst: lock is discarded and any pending rvalid is dropped. The first cycle after reset behaves as OPEN.
- Simultaneous events: lock deassert and MAX_BURST reached in the same grant → next state OPEN. lock is ignored on a non-granted requester.
- burst_cnt is width clog2(MAX_BURST+1) and saturates; it never wraps.

## Structure
- Package mem_arb_pkg holds:
  - state enum {ST_OPEN, ST_LOCKED};
  - requester id typedef (1 bit);
  - default width constants ADDR_W=16, DATA_W=32.
- Sub-module arb_rr2: combinational 2-way round-robin picker (req[1:0], last → gnt[1:0]). mem_arbiter wraps it with lock/burst FSM, mux, and rvalid register.

## Test plan
- Single master: req0 read addr 0x0005 (mem[5]=0x1234ABCD) → gnt0 same cycle; next cycle rvalid0=1, rdata=0x1234ABCD, rvalid1=0.
- Contention: req0 and req1 both reads every cycle for 4 cycles after reset → grants alternate 0,1,0,1; rvalid follows each grant by one cycle.
- Write: req1 we=1 addr 0x0010 wdata 0xDEADBEEF → mem_we=1 that cycle; no rvalid. Subsequent req0 read 0x0010 returns 0xDEADBEEF.
- Burst cap (MAX_BURST=8): req1 lock=1 for 12 cycles while req0 held high → gnt1 for 8 cycles, then gnt0 for 1 cycle, then gnt1 resumes.
- Burst without contention: req1 lock=1 for 10 cycles, req0=0 → gnt1 all 10 cycles, no gaps.
- Reset mid-burst: assert reset at burst cycle 3 with a read in flight → no rvalid after reset, gnt0/gnt1=0 during reset. After release, req0 and req1 tie → gnt0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-requester memory arbiter.
//   arbState_t  : arbiter FSM state (no owner / owner holding a burst)
//   reqId_t     : requester index, 0 = CPU, 1 = DMA/bootloader
//   ADDR_W      : default word-address width
//   DATA_W      : default data width
//   otherReq    : the requester that is not the given one
//   idToOneHot  : requester index as a 2-bit one-hot grant vector
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } arbState_t;

    typedef logic reqId_t;

    // With only two requesters the "other" one is simply the inverted index.
    function automatic reqId_t otherReq(input reqId_t id);
        return ~id;
    endfunction

    function automatic logic [1:0] idToOneHot(input reqId_t id);
        return (id == 1'b1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Purely combinational two-way round-robin picker. A lone request is granted
// directly; on a tie the requester that did not win most recently is chosen.
//   i_req  [1:0] : request vector, bit n = requester n
//   i_last       : requester granted most recently
//   o_gnt  [1:0] : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  reqId_t     i_last,
    output logic [1:0] o_gnt
);

    // Tie-break favours whoever is not i_last, which is what makes the
    // alternation fair under continuous contention.
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = idToOneHot(otherReq(i_last));
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous memory between the CPU (requester 0) and
// a second bus master (requester 1). At most one access is granted per cycle,
// grants are combinational, ties are resolved round-robin, and a master can
// hold the memory for a locked burst of up to MAX_BURST consecutive grants
// before being forced to yield to a waiting competitor.
//
// Ports
//   i_clock, i_reset            : clock, synchronous active-high reset
//   i_req0/1, i_we0/1           : request and write (1) / read (0)
//   i_addr0/1, i_wdata0/1       : access address and write data
//   i_lock0/1                   : ask to keep the grant next cycle
//   o_gnt0/1                    : grant, access performed this cycle
//   o_rvalid0/1                 : read data valid for last cycle's read
//   o_rdata                     : shared read data, qualified by o_rvalidN
//   o_mem_addr/we/wdata         : memory command from the granted requester
//   i_mem_rdata                 : memory read data, one cycle after address
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W    = mem_arb_pkg::ADDR_W,
    parameter int DATA_W    = mem_arb_pkg::DATA_W,
    parameter int MAX_BURST = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    import mem_arb_pkg::*;

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arbState_t        r_state;
    reqId_t           r_owner;
    reqId_t           r_lastGnt;
    logic [CNT_W-1:0] r_burstCnt;
    logic             r_rvalid0;
    logic             r_rvalid1;

    logic [1:0]       w_req;
    logic [1:0]       w_rrGnt;
    logic [1:0]       w_gnt;
    logic             w_ownerReq;
    logic             w_otherReq;
    logic             w_burstFull;
    logic             w_lockedActive;
    logic             w_continueBurst;
    logic             w_granted;
    reqId_t           w_gntId;
    logic             w_gntLock;

    assign w_req       = {i_req1, i_req0};
    assign w_ownerReq  = w_req[r_owner];
    assign w_otherReq  = w_req[otherReq(r_owner)];
    assign w_burstFull = (r_burstCnt >= CNT_MAX);

    // The lock only matters while the owner keeps requesting; an owner that
    // drops its request hands control back to plain round-robin this cycle.
    assign w_lockedActive  = (r_state == ST_LOCKED) && w_ownerReq;
    assign w_continueBurst = w_lockedActive && !w_burstFull;

    arb_rr2 u_rr2 (
        .i_req  (w_req),
        .i_last (r_lastGnt),
        .o_gnt  (w_rrGnt)
    );

    // Grant selection. A locked owner keeps the memory until its burst count
    // reaches MAX_BURST; at that point a waiting competitor is served once,
    // otherwise the owner simply carries on with a fresh count.
    always_comb begin
        w_gnt = 2'b00;
        if (i_reset) begin
            w_gnt = 2'b00;
        end else if (w_lockedActive) begin
            if (w_burstFull && w_otherReq) begin
                w_gnt = idToOneHot(otherReq(r_owner));
            end else begin
                w_gnt = idToOneHot(r_owner);
            end
        end else begin
            w_gnt = w_rrGnt;
        end
    end

    assign w_granted = |w_gnt;
    assign w_gntId   = w_gnt[1];
    assign w_gntLock = w_gntId ? i_lock1 : i_lock0;

    // Memory command mux. Everything is forced to zero without a grant so the
    // memory never sees a stray write enable.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (w_gnt[0]) begin
            o_mem_addr  = i_addr0;
            o_mem_we    = i_we0;
            o_mem_wdata = i_wdata0;
        end else if (w_gnt[1]) begin
            o_mem_addr  = i_addr1;
            o_mem_we    = i_we1;
            o_mem_wdata = i_wdata1;
        end
    end

    // Lock/burst FSM. Every grant records the winner for round-robin and
    // becomes the owner; the granted requester's lock decides whether the
    // next cycle is LOCKED. The burst count only advances when the same
    // owner continues below the cap, otherwise a new burst starts at one.
    // The explicit saturation guard keeps the counter from ever wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_OPEN;
            r_owner    <= 1'b0;
            r_lastGnt  <= 1'b1;
            r_burstCnt <= '0;
        end else if (w_granted) begin
            r_lastGnt <= w_gntId;
            r_owner   <= w_gntId;
            if (w_continueBurst) begin
                r_burstCnt <= (r_burstCnt == CNT_MAX) ? CNT_MAX : r_burstCnt + CNT_ONE;
            end else begin
                r_burstCnt <= CNT_ONE;
            end
            r_state <= w_gntLock ? ST_LOCKED : ST_OPEN;
        end else begin
            r_state <= ST_OPEN;
        end
    end

    // Read-valid strobes follow a granted read by exactly one cycle, matching
    // the synchronous memory latency. Reset drops anything in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_gnt[0] & ~i_we0;
            r_rvalid1 <= w_gnt[1] & ~i_we1;
        end
    end

    assign o_gnt0    = w_gnt[0];
    assign o_gnt1    = w_gnt[1];
    assign o_rvalid0 = r_rvalid0;
    assign o_rvalid1 = r_rvalid1;
    assign o_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Drives the arbiter with directed and random traffic, keeps a simple
// synchronous memory model as the environment, and compares every cycle
// against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAX_BURST = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata;
    logic [15:0] memAddr;
    logic        memWe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;

    int errorCount = 0;
    int checkCount = 0;

    // Behavioural model state: lock ownership, run length, last winner.
    bit          mLocked;
    int          mOwner;
    int          mRun;
    int          mLast;
    int          lastG;
    bit          expRv0;
    bit          expRv1;
    logic [31:0] expRdata;
    logic [31:0] refMem [logic [15:0]];
    logic [31:0] envMem [logic [15:0]];

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W    (16),
        .DATA_W    (32),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .i_lock0     (lock0),
        .i_lock1     (lock1),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_rvalid0   (rvalid0),
        .o_rvalid1   (rvalid1),
        .o_rdata     (rdata),
        .o_mem_addr  (memAddr),
        .o_mem_we    (memWe),
        .o_mem_wdata (memWdata),
        .i_mem_rdata (memRdata)
    );

    // Power-up memory contents; word 5 holds a known pattern.
    function automatic logic [31:0] initWord(input logic [15:0] a);
        if (a == 16'h0005) return 32'h1234ABCD;
        return {16'hC0DE, a};
    endfunction

    function automatic logic [31:0] refRead(input logic [15:0] a);
        if (refMem.exists(a)) return refMem[a];
        return initWord(a);
    endfunction

    // Environment: single-port memory with one-cycle read latency.
    always @(posedge clock) begin : envMemory
        logic [31:0] readWord;
        readWord = envMem.exists(memAddr) ? envMem[memAddr] : initWord(memAddr);
        if (memWe) envMem[memAddr] = memWdata;
        memRdata <= readWord;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Who should win this cycle: -1 none, 0 or 1.
    function automatic int predictGrant(input bit rst, input bit r0, input bit r1);
        bit rq [2];
        rq[0] = r0;
        rq[1] = r1;
        if (rst) return -1;
        if (mLocked && rq[mOwner]) begin
            if (mRun < MAX_BURST) return mOwner;
            if (rq[1 - mOwner])   return 1 - mOwner;
            return mOwner;
        end
        if (r0 && r1) return 1 - mLast;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    // One clock cycle: check last cycle's read return, drive new inputs,
    // check the combinational grant/mux, then advance the model.
    task automatic applyStimulus(input bit rst,
                                 input bit r0, input bit w0, input logic [15:0] a0, input logic [31:0] d0, input bit l0,
                                 input bit r1, input bit w1, input logic [15:0] a1, input logic [31:0] d1, input bit l1);
        int g;
        bit lk;
        @(negedge clock);
        checkOutput("rvalid0", 32'(rvalid0), 32'(expRv0));
        checkOutput("rvalid1", 32'(rvalid1), 32'(expRv1));
        if (expRv0 || expRv1) checkOutput("rdata", rdata, expRdata);

        reset = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #1;
        g = predictGrant(rst, r0, r1);
        checkOutput("gnt0", 32'(gnt0), 32'(g == 0));
        checkOutput("gnt1", 32'(gnt1), 32'(g == 1));
        checkOutput("mem_we", 32'(memWe), (g == 0) ? 32'(w0) : (g == 1) ? 32'(w1) : 32'd0);
        checkOutput("mem_addr", 32'(memAddr), (g == 0) ? 32'(a0) : (g == 1) ? 32'(a1) : 32'd0);
        checkOutput("mem_wdata", memWdata, (g == 0) ? d0 : (g == 1) ? d1 : 32'd0);

        expRv0 = (g == 0) && !w0;
        expRv1 = (g == 1) && !w1;
        if (expRv0) expRdata = refRead(a0);
        if (expRv1) expRdata = refRead(a1);
        if (g == 0 && w0) refMem[a0] = d0;
        if (g == 1 && w1) refMem[a1] = d1;

        if (rst) begin
            mLocked = 1'b0;
            mLast   = 1;
            mRun    = 0;
        end else if (g < 0) begin
            mLocked = 1'b0;
        end else begin
            lk = (g == 0) ? l0 : l1;
            if (mLocked && g == mOwner && mRun < MAX_BURST) mRun++;
            else mRun = 1;
            mLocked = lk;
            mOwner  = g;
            mLast   = g;
        end
        lastG = g;
    endtask

    // Random-phase stimulus state (held until granted).
    bit          rRst, rR0, rW0, rL0, rR1, rW1, rL1, hold0, hold1;
    logic [15:0] rA0, rA1;
    logic [31:0] rD0, rD1;

    initial begin
        mLocked = 1'b0; mOwner = 0; mRun = 0; mLast = 1; lastG = -1;
        expRv0 = 1'b0; expRv1 = 1'b0; expRdata = '0;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset: requests must be ignored
        applyStimulus(1, 1, 1, 16'h0001, 32'h1, 1, 1, 1, 16'h0002, 32'h2, 1);
        applyStimulus(1, 1, 0, 16'h0003, 32'h3, 0, 1, 0, 16'h0004, 32'h4, 0);

        // Single master read of word 5
        applyStimulus(0, 1, 0, 16'h0005, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);

        // Write from requester 1, then read back from requester 0
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 1, 1, 16'h0010, 32'hDEADBEEF, 0);
        applyStimulus(0, 1, 0, 16'h0010, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);

        // Contention straight after reset
        applyStimulus(1, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 0, 16'(i), 32'h0, 0, 1, 0, 16'(16 + i), 32'h0, 0);

        // Burst cap with a competitor waiting
        for (int i = 0; i < 12; i++)
            applyStimulus(0, 1, 0, 16'h0007, 32'h0, 0, 1, 0, 16'(32 + i), 32'h0, 1);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);

        // Long burst with no competitor
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 1, (i % 2) == 1, 16'(48 + i), 32'(i * 3), 1);

        // Reset in the middle of a locked read burst
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 1, 0, 16'h0040, 32'h0, 1);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 1, 0, 16'h0041, 32'h0, 1);
        applyStimulus(1, 1, 0, 16'h0005, 32'h0, 1, 1, 0, 16'h0042, 32'h0, 1);
        applyStimulus(0, 1, 0, 16'h0005, 32'h0, 0, 1, 0, 16'h0042, 32'h0, 0);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);

        // Random traffic; requesters hold their command until granted
        hold0 = 0; hold1 = 0;
        rR0 = 0; rW0 = 0; rA0 = '0; rD0 = '0;
        rR1 = 0; rW1 = 0; rA1 = '0; rD1 = '0;
        for (int c = 0; c < 400; c++) begin
            rRst = ($urandom_range(0, 63) == 0);
            if (!hold0) begin
                rR0 = ($urandom_range(0, 2) != 0);
                rW0 = ($urandom_range(0, 2) == 0);
                rA0 = 16'($urandom_range(0, 15));
                rD0 = $urandom;
            end
            if (!hold1) begin
                rR1 = ($urandom_range(0, 3) != 0);
                rW1 = ($urandom_range(0, 2) == 0);
                rA1 = 16'($urandom_range(0, 15));
                rD1 = $urandom;
            end
            rL0 = ($urandom_range(0, 3) == 0);
            rL1 = ($urandom_range(0, 4) != 0);
            applyStimulus(rRst, rR0, rW0, rA0, rD0, rL0, rR1, rW1, rA1, rD1, rL1);
            hold0 = rR0 && !rRst && (lastG != 0);
            hold1 = rR1 && !rRst && (lastG != 1);
        end
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);
        applyStimulus(0, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 16'h0000, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
